// File: rtl/async_fifo_wptr_full.sv
// Write-side pointer and full-flag generator for an async FIFO.
// Keeps binary and Gray write pointers and syncs the read Gray pointer into wclk.
module async_fifo_wptr_full #(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned AFULL_THRESH = 14,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray_async,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  wovf
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AfullThresh = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_q, wgray_q, wcount_q;
  logic          wfull_q, wafull_q, wovf_q;
  logic [PW-1:0] sync_q [SYNC_STAGES];

  logic [PW-1:0] rq_gray, rq_bin;
  logic [PW-1:0] wbin_d, wgray_d, wcount_d, full_gray;
  logic          wfull_d, wafull_d;

  assign rq_gray = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    logic acc;
    acc    = 1'b0;
    rq_bin = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      acc       = acc ^ rq_gray[i];
      rq_bin[i] = acc;
    end
  end

  always_comb begin
    wen       = winc & ~wfull_q;
    wbin_d    = wbin_q + PW'(wen);
    wgray_d   = wbin_d ^ (wbin_d >> 1);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_gray = {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]};
    wfull_d   = (wgray_d == full_gray);
    wcount_d  = wbin_d - rq_bin;
    wafull_d  = (wcount_d >= AfullThresh);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wcount_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      wbin_q    <= wbin_d;
      wgray_q   <= wgray_d;
      wcount_q  <= wcount_d;
      wfull_q   <= wfull_d;
      wafull_q  <= wafull_d;
      wovf_q    <= wovf_q | (winc & wfull_q);
      sync_q[0] <= rptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray    = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wcount       = wcount_q;
  assign wovf         = wovf_q;

endmodule
